// File: rtl/vga_rx_decoder.sv
// rtl/vga_rx_decoder.sv - VGA PMOD receiver: sync timing recovery, lock, pixel decode; VGA_RX_PROBE_EN adds pixel probe
module vga_rx_decoder #(
  parameter int H_VIS       = 640,
  parameter int H_OFS       = 144,
  parameter int H_TOTAL     = 800,
  parameter int V_VIS       = 480,
  parameter int V_OFS       = 35,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pmod_in,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic [5:0] rx_rgb,
  output logic       rx_active,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic [5:0] probe_rgb,
  output logic       probe_valid
);

  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] H_LO    = 10'(H_OFS);
  localparam logic [9:0] H_HI    = 10'(H_OFS + H_VIS);
  localparam logic [9:0] V_LO    = 10'(V_OFS);
  localparam logic [9:0] V_HI    = 10'(V_OFS + V_VIS);
  localparam logic [9:0] H_LEN   = 10'(H_TOTAL);
  localparam logic [9:0] V_LEN   = 10'(V_TOTAL);
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } lock_state_t;

  lock_state_t state;
  logic [2:0]  good;
  logic [7:0]  s1;
  logic [1:0]  s2_sync;   // {hsync, vsync} of the previous sample; colour is taken from s1 only
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        hfall;
  logic        vfall;
  logic [9:0]  hcnt_inc;
  logic [9:0]  vcnt_inc;
  logic [9:0]  hcnt_nxt;
  logic [9:0]  vcnt_nxt;
  logic [9:0]  lines_done;
  logic        timing_bad;
  logic        active_nxt;
  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic [5:0]  rgb_nxt;

  // Edge detection, counter next values and the pixel window. Output registers load the
  // next counter values so that rx_x/rx_y line up with the colour taken from s1.
  always_comb begin
    hfall      = s2_sync[1] & ~s1[7];
    vfall      = s2_sync[0] & ~s1[3];
    hcnt_inc   = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1;
    vcnt_inc   = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1;
    hcnt_nxt   = hfall ? 10'd0 : hcnt_inc;
    vcnt_nxt   = vfall ? 10'd0 : (hfall ? vcnt_inc : vcnt);
    // A coincident hsync fall belongs to the frame that is closing.
    lines_done = hfall ? vcnt_inc : vcnt;
    timing_bad = (hfall & (hcnt_inc != H_LEN)) | (vfall & (lines_done != V_LEN));
    active_nxt = locked & (hcnt_nxt >= H_LO) & (hcnt_nxt < H_HI)
                        & (vcnt_nxt >= V_LO) & (vcnt_nxt < V_HI);
    x_nxt      = hcnt_nxt - H_LO;
    y_nxt      = vcnt_nxt - V_LO;
    rgb_nxt    = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
  end

  // Two-stage input sampling of the PMOD bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2_sync <= '0;
    end else begin
      s1      <= pmod_in;
      s2_sync <= {s1[7], s1[3]};
    end
  end

  // Line/frame counters and the measured line length and frame height.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (hfall) line_len <= hcnt_inc;
      if (vfall) frame_lines <= lines_done;
    end
  end

  // Lock FSM: a frame only counts as good if every line and the line total match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_SEARCH;
      good   <= '0;
      locked <= 1'b0;
    end else begin
      unique case (state)
        ST_SEARCH: begin
          if (vfall) begin
            state <= ST_VERIFY;
            good  <= '0;
          end
        end
        ST_VERIFY, ST_LOCKED: begin
          if (timing_bad) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end else if (vfall && state == ST_VERIFY) begin
            good <= good + 3'd1;
            if (good + 3'd1 == LOCK_N) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Recovered pixel outputs; coordinates read as zero outside the locked visible window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_x      <= '0;
      rx_y      <= '0;
      rx_rgb    <= '0;
      rx_active <= 1'b0;
    end else begin
      rx_rgb    <= rgb_nxt;
      rx_active <= active_nxt;
      rx_x      <= active_nxt ? x_nxt : 10'd0;
      rx_y      <= active_nxt ? y_nxt : 10'd0;
    end
  end

`ifdef VGA_RX_PROBE_EN
  // Capture the colour of the selected pixel once per frame, alongside rx_rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= active_nxt && (x_nxt == probe_x) && (y_nxt == probe_y);
      if (active_nxt && (x_nxt == probe_x) && (y_nxt == probe_y)) probe_rgb <= rgb_nxt;
    end
  end
`else
  logic probe_unused;
  assign probe_unused = ^{probe_x, probe_y};
  assign probe_rgb    = '0;
  assign probe_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb/tb_vga_rx_decoder.sv - randomized bench for vga_rx_decoder against an event-level timing model
module tb_vga_rx_decoder;

  localparam int HT = 40, HS_W = 6, HO = 10, HV = 24;
  localparam int VT = 20, VO = 4, VV = 12, LF = 2;
  localparam int PX = 5, PY = 3;
  localparam int VSH = 13;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pmod_in;
  logic [9:0] rx_x, rx_y, line_len, frame_lines;
  logic [5:0] rx_rgb, probe_rgb;
  logic       rx_active, locked, probe_valid;
  logic [9:0] probe_x = 10'(PX);
  logic [9:0] probe_y = 10'(PY);

  vga_rx_decoder #(
    .H_VIS(HV), .H_OFS(HO), .H_TOTAL(HT), .V_VIS(VV), .V_OFS(VO), .V_TOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in),
    .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb), .rx_active(rx_active), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines),
    .probe_x(probe_x), .probe_y(probe_y), .probe_rgb(probe_rgb), .probe_valid(probe_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int x, y, rgb, act, lock, ll, fl, prgb, pval;
  } rec_t;

  rec_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   n = 0;
  bit   rst_req = 0, rel_pend = 0;
  bit   m_phs, m_pvs;
  int   m_last, m_lines, m_ll, m_fl, m_mode, m_good, m_prgb;
  int   max_x = -1;
  bit   saw_long = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic compare(input rec_t o);
    check("rx_x", int'(rx_x), o.x);
    check("rx_y", int'(rx_y), o.y);
    check("rx_rgb", int'(rx_rgb), o.rgb);
    check("rx_active", int'(rx_active), o.act);
    check("locked", int'(locked), o.lock);
    check("line_len", int'(line_len), o.ll);
    check("frame_lines", int'(frame_lines), o.fl);
    check("probe_rgb", int'(probe_rgb), o.prgb);
    check("probe_valid", int'(probe_valid), o.pval);
  endtask

  task automatic check_zero(input string pfx);
    rec_t z;
    z = '{default: 0};
    check({pfx, "_zero"}, int'(rx_x) + int'(rx_y) + int'(rx_rgb) + int'(line_len) + int'(frame_lines)
          + int'(probe_rgb), 0);
    compare(z);
  endtask

  // One pixel clock: check the output for the sample driven two edges ago, drive the next
  // sample and advance the model, which works on sync-edge events and sample indices.
  task automatic step(input bit hs, input bit vs, input bit [5:0] rgb);
    rec_t r, o;
    bit   hf, vf;
    int   hc;
    @(posedge clk);
    #1;
    n++;
    if (q.size() == 2) begin
      o = q.pop_front();
      if (o.valid) compare(o);
    end
    if (rx_active && int'(rx_x) > max_x) max_x = int'(rx_x);
    if (line_len == 10'(HT + 1)) saw_long = 1;
    pmod_in = {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
    r = '{default: 0};
    if (rst_req) begin
      rst_req = 0;
      rst_n = 1'b0;
      #1;
      check_zero("rst_mid");
      foreach (q[i]) q[i].valid = 0;
      rel_pend = 1;
      q.push_back(r);
      return;
    end
    if (rel_pend) begin
      rel_pend = 0;
      rst_n = 1'b1;
      m_phs = 0; m_pvs = 0;
      m_last = n - 2;
      m_lines = 0; m_ll = 0; m_fl = 0; m_mode = 0; m_good = 0; m_prgb = 0;
    end
    if (!rst_n) begin
      q.push_back(r);
      return;
    end
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    m_phs = hs;
    m_pvs = vs;
    if (hf) begin
      m_ll = sat(n - m_last);
      m_last = n;
      m_lines = sat(m_lines + 1);
    end
    hc = sat(n - m_last);
    if (vf) begin
      m_fl = m_lines;
      m_lines = 0;
    end
    if (m_mode == 0) begin
      if (vf) begin m_mode = 1; m_good = 0; end
    end else if ((hf && m_ll != HT) || (vf && m_fl != VT)) begin
      m_mode = 0;
    end else if (vf && m_mode == 1) begin
      m_good++;
      if (m_good == LF) m_mode = 2;
    end
    r.valid = 1;
    r.act   = (m_mode == 2 && hc >= HO && hc < HO + HV && m_lines >= VO && m_lines < VO + VV) ? 1 : 0;
    r.x     = r.act ? hc - HO : 0;
    r.y     = r.act ? m_lines - VO : 0;
    r.rgb   = int'(rgb);
    r.lock  = (m_mode == 2) ? 1 : 0;
    r.ll    = m_ll;
    r.fl    = m_fl;
`ifdef VGA_RX_PROBE_EN
    r.pval  = (r.act == 1 && r.x == PX && r.y == PY) ? 1 : 0;
    if (r.pval == 1) m_prgb = int'(rgb);
`endif
    r.prgb  = m_prgb;
    q.push_back(r);
  endtask

  // Lines begin at the hsync fall; vsync is low for two lines starting at column vs_h of line 0.
  task automatic frame(input int vs_h, input int start_line, input int long_line, input int extra,
                       input int rst_line);
    int len;
    bit hs, in_vs;
    for (int l = start_line; l < VT; l++) begin
      len = HT + ((l == long_line) ? extra : 0);
      for (int h = 0; h < len; h++) begin
        hs    = (h >= HS_W);
        in_vs = (l == 0 && h >= vs_h) || (l == 1) || (l == 2 && h < vs_h);
        if (l == rst_line && h == 20) rst_req = 1;
        step(hs, !in_vs, 6'($urandom));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pmod_in = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'($urandom));
    check_zero("por");

    // Release in the middle of a frame; lock follows the third vsync fall.
    rel_pend = 1;
    frame(VSH, 5, -1, 0, -1);
    frame(VSH, 0, -1, 0, -1);
    frame(VSH, 0, -1, 0, -1);
    check("lock_before_3rd_vfall", int'(locked), 0);
    frame(VSH, 0, -1, 0, -1);
    check("lock_after_3rd_vfall", int'(locked), 1);
    check("line_len_std", int'(line_len), HT);
    check("frame_lines_std", int'(frame_lines), VT);
    frame(VSH, 0, -1, 0, -1);
    check("max_active_x", max_x, HV - 1);

    // One stretched line drops lock; three clean vsync falls relock.
    frame(VSH, 0, 8, 1, -1);
    check("saw_long_line", int'(saw_long), 1);
    check("unlock_on_long", int'(locked), 0);
    frame(VSH, 0, -1, 0, -1);
    frame(VSH, 0, -1, 0, -1);
    check("still_unlocked", int'(locked), 0);
    frame(VSH, 0, -1, 0, -1);
    check("relock_long", int'(locked), 1);

    // Coincident hsync/vsync falls.
    frame(0, 0, -1, 0, -1);
    frame(0, 0, -1, 0, -1);
    check("coinc_frame_lines", int'(frame_lines), VT);
    check("coinc_locked", int'(locked), 1);

    // One-cycle reset mid-line.
    frame(0, 0, -1, 0, 10);
    check("rst_unlocked", int'(locked), 0);
    check("rst_frame_lines", int'(frame_lines), 0);
    for (int i = 0; i < 3; i++) frame(VSH, 0, -1, 0, -1);
    check("rst_relock", int'(locked), 1);

    // Syncs absent: counters saturate, measurements hold.
    for (int i = 0; i < 1500; i++) step(1'b1, 1'b1, 6'($urandom));
    check("hold_line_len", int'(line_len), HT);
    check("hold_frame_lines", int'(frame_lines), VT);
    for (int i = 0; i < 4; i++) frame(VSH, 0, -1, 0, -1);
    check("resume_locked", int'(locked), 1);

    // Random vsync phase and occasional line-length faults.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0)
        frame($urandom_range(0, HT - 1), 0, $urandom_range(3, VT - 1), ($urandom_range(0, 1) == 0) ? -1 : 1, -1);
      else
        frame($urandom_range(0, HT - 1), 0, -1, 0, -1);
    end
    step(1'b1, 1'b1, 6'd0);
    step(1'b1, 1'b1, 6'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
